// File: rtl/router_dst_port.sv
// Per-destination output buffer: packet-aware byte FIFO with a read-timeout flush watchdog.
// Latency: a written byte is visible on valid_out next cycle; data_out is registered one cycle after read_enb.
// Backpressure: full drops further writes; an idle reader for TIMEOUT cycles flushes the buffer and pulses soft_reset.
module router_dst_port #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              write_enb,
    input  logic [DATA_W-1:0] data_in,
    input  logic              lfd_state,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              soft_reset
);

    localparam int AW   = $clog2(DEPTH);
    localparam int WDW  = $clog2(TIMEOUT + 1);
    // header[7:2] + 1 can reach 64, so the counter needs one bit more than the length field
    localparam int CNTW = DATA_W - 1;

    // Bit DATA_W of each entry remembers whether the byte was a packet header
    logic [DATA_W:0]     mem [DEPTH];

    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [CNTW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [WDW-1:0]      wd_cnt_q, wd_cnt_d;
    logic                soft_reset_q, soft_reset_d;

    logic                wr_acc;
    logic                rd_acc;
    logic                wd_fire;
    logic                mem_we;
    logic [DATA_W:0]     rd_word;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign valid_out = !empty;
    assign data_out  = data_out_q;
    assign soft_reset = soft_reset_q;

    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    // Fires on the TIMEOUT-th consecutive cycle with data waiting and no read
    assign wd_fire = !empty && !read_enb && (wd_cnt_q == WDW'(TIMEOUT - 1));
    // A write landing in the flush cycle would be orphaned by the pointer reset, so it is discarded
    assign mem_we  = wr_acc && !wd_fire;
    assign rd_word = mem[rd_ptr_q[AW-1:0]];

    // Next-state for pointers, output byte, packet counter and watchdog
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_out_d   = data_out_q;
        byte_cnt_d   = byte_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        soft_reset_d = 1'b0;

        if (wd_fire) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            data_out_d   = '0;
            byte_cnt_d   = '0;
            wd_cnt_d     = '0;
            soft_reset_d = 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_word[DATA_W-1:0];
                // A header reloads the count even mid-packet; that malformed case is not flagged
                if (rd_word[DATA_W]) begin
                    byte_cnt_d = CNTW'(rd_word[DATA_W-1:2]) + CNTW'(1);
                end else if (byte_cnt_q != '0) begin
                    byte_cnt_d = byte_cnt_q - CNTW'(1);
                end
            end
            if (empty || rd_acc) begin
                wd_cnt_d = '0;
            end else if (!read_enb) begin
                wd_cnt_d = wd_cnt_q + WDW'(1);
            end
        end
    end

    // State registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_out_q   <= '0;
            byte_cnt_q   <= '0;
            wd_cnt_q     <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_out_q   <= data_out_d;
            byte_cnt_q   <= byte_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    // Storage array; contents are meaningless whenever the pointers say empty, so no reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

endmodule

// File: tb/tb_router_dst_port.sv
module tb_router_dst_port;

    logic       clock;
    logic       resetn;
    logic       write_enb;
    logic [7:0] data_in;
    logic       lfd_state;
    logic       read_enb;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       soft_reset;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    bit         pend = 1'b0;
    bit         sr_seen;

    router_dst_port #(.DEPTH(16), .DATA_W(8), .TIMEOUT(30)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .write_enb  (write_enb),
        .data_in    (data_in),
        .lfd_state  (lfd_state),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .full       (full),
        .empty      (empty),
        .soft_reset (soft_reset)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic l, input bit expect_acc);
        write_enb = 1'b1;
        data_in   = d;
        lfd_state = l;
        if (expect_acc) exp_q.push_back(d);
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    // Monitor: a read handshake seen before an edge produces a byte on data_out after that edge
    always @(negedge clock) begin
        if (pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got 0x%0h, expected no output at %0t", data_out, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL sb_data: got 0x%0h, expected 0x%0h at %0t", data_out, e, $time);
                end
            end
        end
        pend = resetn && read_enb && valid_out;
    end

    initial begin
        resetn    = 1'b0;
        write_enb = 1'b0;
        data_in   = 8'h00;
        lfd_state = 1'b0;
        read_enb  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_valid", {31'd0, valid_out}, 0);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_data", {24'd0, data_out}, 0);
        chk("rst_sr", {31'd0, soft_reset}, 0);
        resetn = 1'b1;

        // Reset asserted mid-write
        write_enb = 1'b1;
        data_in   = 8'h55;
        @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        chk("midwr_empty", {31'd0, empty}, 1);
        chk("midwr_valid", {31'd0, valid_out}, 0);
        chk("midwr_data", {24'd0, data_out}, 0);
        chk("midwr_sr", {31'd0, soft_reset}, 0);
        write_enb = 1'b0;
        tick();
        resetn   = 1'b1;
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        chk("rd_after_rst_data", {24'd0, data_out}, 0);
        chk("rd_after_rst_empty", {31'd0, empty}, 1);

        // Packet transfer: header 0x0D -> length 3, counter loads 4
        wr(8'h0D, 1'b1, 1'b1);
        wr(8'hA1, 1'b0, 1'b1);
        wr(8'hA2, 1'b0, 1'b1);
        wr(8'hA3, 1'b0, 1'b1);
        wr(8'h0F, 1'b0, 1'b1);
        read_enb = 1'b1;
        tick();
        chk("pkt_cnt_hdr", {25'd0, dut.byte_cnt_q}, 4);
        tick();
        chk("pkt_cnt_b1", {25'd0, dut.byte_cnt_q}, 3);
        repeat (3) tick();
        read_enb = 1'b0;
        chk("pkt_cnt_end", {25'd0, dut.byte_cnt_q}, 0);
        chk("pkt_empty", {31'd0, empty}, 1);

        // Fill to full, overflow byte must be dropped
        for (int i = 0; i < 16; i++) begin
            chk("fill_notfull", {31'd0, full}, 0);
            wr(8'(i), 1'b0, 1'b1);
        end
        chk("full_set", {31'd0, full}, 1);
        wr(8'hFF, 1'b0, 1'b0);
        chk("full_after_ovf", {31'd0, full}, 1);
        read_enb = 1'b1;
        repeat (16) tick();
        read_enb = 1'b0;
        chk("drain_empty", {31'd0, empty}, 1);
        chk("drain_full", {31'd0, full}, 0);

        // Simultaneous read/write with 4 stored, crossing pointer wrap
        for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            write_enb = 1'b1;
            read_enb  = 1'b1;
            data_in   = 8'hC0 + 8'(i);
            exp_q.push_back(data_in);
            tick();
            chk("simul_occ", {27'd0, 5'(dut.wr_ptr_q - dut.rd_ptr_q)}, 4);
        end
        write_enb = 1'b0;
        repeat (4) tick();
        read_enb = 1'b0;
        chk("simul_empty", {31'd0, empty}, 1);

        // Read and write together on empty: only the write lands
        write_enb = 1'b1;
        read_enb  = 1'b1;
        data_in   = 8'h77;
        exp_q.push_back(8'h77);
        tick();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        chk("erw_valid", {31'd0, valid_out}, 1);
        chk("erw_hold", {24'd0, data_out}, 32'hC7);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        chk("erw_empty", {31'd0, empty}, 1);

        // Watchdog: one byte left unread for 30 cycles
        wr(8'h3C, 1'b0, 1'b1);
        sr_seen = 1'b0;
        repeat (29) begin
            tick();
            if (soft_reset) sr_seen = 1'b1;
        end
        chk("wd_early", {31'd0, sr_seen}, 0);
        tick();
        chk("wd_fire", {31'd0, soft_reset}, 1);
        chk("wd_empty", {31'd0, empty}, 1);
        chk("wd_valid", {31'd0, valid_out}, 0);
        chk("wd_data", {24'd0, data_out}, 0);
        exp_q.delete();
        tick();
        chk("wd_pulse_len", {31'd0, soft_reset}, 0);

        // Watchdog rescued by a read on cycle 29
        wr(8'h5A, 1'b0, 1'b1);
        sr_seen = 1'b0;
        repeat (28) begin
            tick();
            if (soft_reset) sr_seen = 1'b1;
        end
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        repeat (40) begin
            tick();
            if (soft_reset) sr_seen = 1'b1;
        end
        chk("wd_rescued", {31'd0, sr_seen}, 0);

        // Async reset with 10 bytes buffered and watchdog at 20
        for (int i = 0; i < 10; i++) wr(8'h90 + 8'(i), 1'b0, 1'b0);
        repeat (11) tick();
        chk("pre_rst_wd", {27'd0, dut.wd_cnt_q}, 20);
        #3 resetn = 1'b0;
        #1;
        chk("arst_empty", {31'd0, empty}, 1);
        chk("arst_valid", {31'd0, valid_out}, 0);
        chk("arst_full", {31'd0, full}, 0);
        chk("arst_data", {24'd0, data_out}, 0);
        tick();
        resetn  = 1'b1;
        sr_seen = 1'b0;
        repeat (40) begin
            tick();
            if (soft_reset) sr_seen = 1'b1;
        end
        chk("arst_no_sr", {31'd0, sr_seen}, 0);
        chk("arst_still_empty", {31'd0, empty}, 1);

        tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
